// File: rtl/pool_slice_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pool_slice_serializer
// Description : Latches one pooled PHxPW slice of DATA_WIDTH words and emits
//               it word by word in raster order on a valid/ready stream,
//               tagging each word with channel/row/col coordinates. A new
//               slice can be taken in the same cycle the final word leaves,
//               so back-to-back slices stream without a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_slice_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 6,
    parameter int PH         = 14,
    parameter int PW         = 14
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [0:PH*PW*DATA_WIDTH-1]   in_slice,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(D)-1:0]          out_chan,
    output logic [$clog2(PH)-1:0]         out_row,
    output logic [$clog2(PW)-1:0]         out_col,
    output logic                          out_last,
    output logic                          frame_done
);

    localparam int N      = PH * PW;
    localparam int IDX_W  = $clog2(N);
    localparam int CHAN_W = $clog2(D);
    localparam int ROW_W  = $clog2(PH);
    localparam int COL_W  = $clog2(PW);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(D - 1);
    localparam logic [CHAN_W-1:0] CHAN_ONE  = CHAN_W'(1);
    localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(PW - 1);
    localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);

    typedef enum logic [0:0] {
        EMPTY  = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [CHAN_W-1:0]     chan_q, chan_d;
    logic                  frame_done_q, frame_done_d;
    logic [DATA_WIDTH-1:0] slice_buf_q [N];
    logic                  last_word;
    logic                  load;

    assign last_word = (idx_q == IDX_LAST);
    // A slice is captured whenever the upstream handshake completes.
    assign load      = in_valid & in_ready;

    // Next-state, index advance and handshake outputs.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        row_d        = row_q;
        col_d        = col_q;
        chan_d       = chan_q;
        frame_done_d = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        case (state_q)
            EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                out_last  = (chan_q == CHAN_LAST) && last_word;
                if (out_ready) begin
                    if (last_word) begin
                        // Final word leaves: open the input for a zero-bubble refill.
                        in_ready     = 1'b1;
                        idx_d        = '0;
                        row_d        = '0;
                        col_d        = '0;
                        chan_d       = (chan_q == CHAN_LAST) ? '0 : chan_q + CHAN_ONE;
                        frame_done_d = (chan_q == CHAN_LAST);
                        state_d      = in_valid ? STREAM : EMPTY;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + ROW_ONE;
                        end else begin
                            col_d = col_q + COL_ONE;
                        end
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Control state with asynchronous reset back to an idle, zeroed position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            idx_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            chan_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            row_q        <= row_d;
            col_q        <= col_d;
            chan_q       <= chan_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Slice buffer is written only on acceptance; it is never cleared.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < N; k++) begin
                slice_buf_q[k] <= in_slice[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Gating by out_valid keeps out_data at zero out of reset without clearing the buffer.
    assign out_data   = out_valid ? slice_buf_q[idx_q] : '0;
    assign out_chan   = chan_q;
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_slice_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pool_slice_serializer
// Description : Directed self-checking bench for pool_slice_serializer with
//               default parameters (16-bit words, 6 channels, 14x14 slice).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_slice_serializer;

    localparam int DW = 16;
    localparam int D  = 6;
    localparam int PH = 14;
    localparam int PW = 14;
    localparam int N  = PH * PW;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [0:N*DW-1] in_slice;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_chan;
    logic [3:0]      out_row;
    logic [3:0]      out_col;
    logic            out_last;
    logic            frame_done;

    int vectors = 0;
    int errors  = 0;

    pool_slice_serializer #(
        .DATA_WIDTH (DW),
        .D          (D),
        .PH         (PH),
        .PW         (PW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_slice   (in_slice),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slice whose word k holds base + k.
    function automatic logic [0:N*DW-1] make_slice(input logic [15:0] base);
        logic [0:N*DW-1] s;
        for (int k = 0; k < N; k++) s[k*DW +: DW] = base + 16'(k);
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_slice = '0;
        @(negedge clk);
        vectors++;
        if ({out_valid, out_last, frame_done} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {out_valid, out_last, frame_done});
        end
        vectors++;
        if ({out_chan, out_row, out_col, out_data} !== 27'd0) begin
            errors++; $display("FAIL reset_coords: got chan=%0d row=%0d col=%0d data=%0h want all 0",
                               out_chan, out_row, out_col, out_data);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_release: got in_ready/out_valid=%b want 10", {in_ready, out_valid});
        end
    endtask

    // One slice with word k = k, out_ready held high; then idle return.
    task automatic test_single();
        in_slice = make_slice(16'h0000); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL single_accept_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            #1;
            vectors++;
            if ({out_valid, out_last, frame_done} !== 3'b100 || out_data !== 16'(i)) begin
                errors++; $display("FAIL single_word[%0d]: got v/l/f=%b data=%0d want 100 data=%0d",
                                   i, {out_valid, out_last, frame_done}, out_data, i);
            end
            vectors++;
            if (out_chan !== 3'd0 || out_row !== 4'(i / PW) || out_col !== 4'(i % PW)) begin
                errors++; $display("FAIL single_coord[%0d]: got %0d/%0d/%0d want 0/%0d/%0d",
                                   i, out_chan, out_row, out_col, i / PW, i % PW);
            end
            vectors++;
            if (in_ready !== (i == N - 1)) begin
                errors++; $display("FAIL single_in_ready[%0d]: got %b want %b", i, in_ready, (i == N - 1));
            end
            @(negedge clk);
        end
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++;
            if ({out_valid, in_ready, frame_done} !== 3'b010 || out_chan !== 3'd1) begin
                errors++; $display("FAIL idle_return[%0d]: got v/r/f=%b chan=%0d want 010 chan=1",
                                   c, {out_valid, in_ready, frame_done}, out_chan);
            end
            @(negedge clk);
        end
    endtask

    // Six slices back to back forming a full frame.
    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        in_slice = make_slice(16'h1000); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        for (int s = 0; s < D; s++) begin
            for (int i = 0; i < N; i++) begin
                if (i == 0) in_slice = make_slice(16'(16'h1000 * (s + 2)));
                if (s == D - 1 && i == N - 1) in_valid = 1'b0;
                #1;
                vectors++;
                if ({out_valid, out_last, frame_done} !== {1'b1, (s == D - 1 && i == N - 1), 1'b0} ||
                    out_data !== 16'(16'h1000 * (s + 1) + i) || out_chan !== 3'(s)) begin
                    errors++; $display("FAIL b2b_word[%0d.%0d]: got v/l/f=%b data=%0h chan=%0d want data=%0h chan=%0d",
                                       s, i, {out_valid, out_last, frame_done}, out_data, out_chan,
                                       16'(16'h1000 * (s + 1) + i), s);
                end
                vectors++;
                if (in_ready !== (i == N - 1)) begin
                    errors++; $display("FAIL b2b_in_ready[%0d.%0d]: got %b want %b", s, i, in_ready, (i == N - 1));
                end
                @(negedge clk);
            end
        end
        #1;
        vectors++;
        if ({frame_done, out_valid, out_last} !== 3'b100 || out_chan !== 3'd0) begin
            errors++; $display("FAIL frame_done_pulse: got f/v/l=%b chan=%0d want 100 chan=0",
                               {frame_done, out_valid, out_last}, out_chan);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL frame_done_width: got %b want 0", frame_done);
        end
    endtask

    // Random downstream stalls with a churning, unaccepted in_slice.
    task automatic test_stall();
        int exp_i;
        int cycles;
        logic rdy;
        do_reset();
        @(negedge clk);
        in_slice = make_slice(16'hA000); in_valid = 1'b1;
        @(negedge clk);
        exp_i = 0; cycles = 0;
        while (exp_i < N && cycles < 3000) begin
            rdy       = 1'($urandom_range(0, 1));
            out_ready = rdy;
            in_slice  = make_slice(16'($urandom));
            in_valid  = (exp_i != N - 1);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 16'(16'hA000 + exp_i) ||
                out_row !== 4'(exp_i / PW) || out_col !== 4'(exp_i % PW)) begin
                errors++; $display("FAIL stall_word[%0d]: got v=%b data=%0h row=%0d col=%0d want data=%0h row=%0d col=%0d",
                                   exp_i, out_valid, out_data, out_row, out_col,
                                   16'(16'hA000 + exp_i), exp_i / PW, exp_i % PW);
            end
            vectors++;
            if (in_ready !== (exp_i == N - 1 && rdy)) begin
                errors++; $display("FAIL stall_in_ready[%0d]: got %b want %b", exp_i, in_ready, (exp_i == N - 1 && rdy));
            end
            if (rdy) exp_i++;
            cycles++;
            @(negedge clk);
        end
        vectors++;
        if (exp_i != N) begin
            errors++; $display("FAIL stall_timeout: got %0d words want %0d", exp_i, N);
        end
        #1;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL stall_end_empty: got v/r=%b want 01", {out_valid, in_ready});
        end
    endtask

    // Asynchronous reset at word 100 of channel 3, then a fresh slice.
    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        in_slice = make_slice(16'h3000); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        repeat (3 * N + 100) @(negedge clk);
        #1;
        vectors++;
        if (out_chan !== 3'd3 || out_data !== 16'h3064 || out_row !== 4'd7 || out_col !== 4'd2) begin
            errors++; $display("FAIL mid_position: got chan=%0d data=%0h row=%0d col=%0d want 3 3064 7 2",
                               out_chan, out_data, out_row, out_col);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({out_valid, out_last, frame_done} !== 3'b000 ||
            {out_chan, out_row, out_col, out_data} !== 27'd0) begin
            errors++; $display("FAIL mid_reset: got v/l/f=%b chan=%0d row=%0d col=%0d data=%0h want all 0",
                               {out_valid, out_last, frame_done}, out_chan, out_row, out_col, out_data);
        end
        @(negedge clk);
        reset = 1'b0; in_slice = make_slice(16'h5000); in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_release_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 16'(16'h5000 + i) || out_chan !== 3'd0 ||
                out_row !== 4'd0 || out_col !== 4'(i)) begin
                errors++; $display("FAIL mid_restart[%0d]: got v=%b data=%0h chan=%0d row=%0d col=%0d want data=%0h chan=0 row=0 col=%0d",
                                   i, out_valid, out_data, out_chan, out_row, out_col, 16'(16'h5000 + i), i);
            end
            @(negedge clk);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pool_slice_serializer.md
POOL_SLICE_SERIALIZER -- requirements
Module: pool_slice_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, bit width of one pooled word.
REQ-002 The block SHALL have parameter D, default 6, number of channel slices per frame.
REQ-003 The block SHALL have parameter PH, default 14, pooled slice height.
REQ-004 The block SHALL have parameter PW, default 14, pooled slice width.
REQ-005 The block SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-007 The block SHALL have port in_valid, input, 1, upstream slice valid.
REQ-008 The block SHALL have port in_ready, output, 1, block can accept a slice this cycle.
REQ-009 The block SHALL have port in_slice, input, [0:PH*PW*DATA_WIDTH-1], one pooled slice; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH], k = row*PW+col.
REQ-010 The block SHALL have port out_valid, output, 1, out_data holds a valid word.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts word.
REQ-012 The block SHALL have port out_data, output, DATA_WIDTH, current word.
REQ-013 The block SHALL have ports out_chan, out_row, out_col, outputs, $clog2(D), $clog2(PH), $clog2(PW) bits, coordinates of out_data.
REQ-014 The block SHALL have port out_last, output, 1, high with final word of channel D-1.
REQ-015 The block SHALL have port frame_done, output, 1, one-cycle pulse after last word of a frame transfers.

Function
REQ-016 The block SHALL implement an FSM with states EMPTY and STREAM.
REQ-017 EMPTY: in_ready=1, out_valid=0; on in_valid&in_ready the slice SHALL be latched into an internal buffer, and the state SHALL become STREAM next cycle with word index 0.
REQ-018 STREAM: out_valid=1, out_data = buffered word at current index; words SHALL be emitted in raster order (col fastest, then row).
REQ-019 A word SHALL transfer only on out_valid&out_ready; the index SHALL advance by exactly one per transfer, and out_data and coordinates SHALL hold stable while out_ready=0.
REQ-020 Latency: first word SHALL appear on out_valid one cycle after slice acceptance.
REQ-021 In STREAM, in_ready SHALL be 1 only in the cycle the final word (index PH*PW-1) transfers; a slice accepted then SHALL be latched and streamed from index 0 next cycle with no bubble.
REQ-022 If the final word transfers and no slice is accepted, the state SHALL return to EMPTY.
REQ-023 out_chan SHALL increment after each completed slice and wrap from D-1 to 0.
REQ-024 out_last SHALL be 1 only when out_valid, out_chan=D-1, and index=PH*PW-1.
REQ-025 frame_done SHALL pulse in the cycle after the out_last word transfers.
REQ-026 in_slice SHALL be ignored when not accepted; buffer contents SHALL change only on acceptance.
REQ-027 Data SHALL pass unmodified, with no arithmetic or sign change.

Reset
REQ-028 On reset assertion, at any time including mid-slice, the state SHALL become EMPTY immediately, with out_valid=0, out_last=0, frame_done=0, in_ready=1 after reset release, and index, out_chan, out_row, and out_col all 0.
REQ-029 Buffer contents need not be cleared; out_data SHALL be 0 after reset until the first acceptance.

Verification
REQ-030 Single slice, word k = k (0..195), out_ready tied 1 -> out_data 0..195 on consecutive cycles starting one cycle after acceptance, row/col wrap at 13, in_ready low throughout except the final-word cycle.
REQ-031 Six back-to-back slices, in_valid held 1, out_ready=1 -> 1176 contiguous words, out_chan 0..5, out_last only on word 1175, frame_done pulse next cycle, out_chan back to 0.
REQ-032 Random out_ready stalls (50%) -> no word lost or duplicated, out_data stable during stall, sequence identical to REQ-030.
REQ-033 in_slice changed while STREAM without acceptance -> emitted words unchanged.
REQ-034 reset asserted at word 100 of channel 3 -> out_valid=0 immediately, next accepted slice streams from index 0, channel 0.
REQ-035 in_valid deasserted at final word -> state EMPTY, out_valid=0 next cycle, in_ready=1.
